// File: rtl/vga_frame_rd_sync.sv
// Video scan timing generator with tear-free frame-buffer switching and
// SDRAM read-FIFO control (read enable, buffer address window, FIFO flush).
module vga_frame_rd_sync #(
  parameter int H_SYNC      = 136,
  parameter int H_BACK      = 160,
  parameter int H_DISP      = 1024,
  parameter int H_FRONT     = 24,
  parameter int H_TOTAL     = 1344,
  parameter int V_SYNC      = 6,
  parameter int V_BACK      = 29,
  parameter int V_DISP      = 768,
  parameter int V_FRONT     = 3,
  parameter int V_TOTAL     = 806,
  parameter int CNT_W       = 12,
  parameter int SYNC_POL    = 1,
  parameter int RD_LEAD     = 1,
  parameter int NUM_BUF     = 4,
  parameter int BUF_W       = 2,
  parameter int ADDR_W      = 23,
  parameter int BUF_STRIDE  = 1048576,
  parameter int FRAME_WORDS = 786432,
  parameter int RST_LEN     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [BUF_W-1:0]  buf_sel,
  input  logic              buf_sel_vld,
  output logic [CNT_W-1:0]  hcnt,
  output logic [CNT_W-1:0]  vcnt,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              rd_en,
  output logic              sdram_rst_n,
  output logic [ADDR_W-1:0] rd_b_addr,
  output logic [ADDR_W-1:0] rd_e_addr,
  output logic [BUF_W-1:0]  active_buf,
  output logic              frame_start,
  output logic              sel_err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam int FL_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYN  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_DE_B = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_DE_E = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] H_RD_B = CNT_W'(H_SYNC + H_BACK - RD_LEAD);
  localparam logic [CNT_W-1:0] H_RD_E = CNT_W'(H_SYNC + H_BACK + H_DISP - RD_LEAD);
  localparam logic [CNT_W-1:0] V_DE_B = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_DE_E = CNT_W'(V_SYNC + V_BACK + V_DISP);
  localparam logic             POL    = (SYNC_POL != 0);

  localparam logic [BUF_W:0]   NUM_BUF_C = (BUF_W+1)'(NUM_BUF);
  localparam logic [ADDR_W:0]  STRIDE_C  = (ADDR_W+1)'(BUF_STRIDE);
  localparam logic [ADDR_W:0]  FWORDS_C  = (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(RST_LEN - 1);

  if (H_TOTAL != H_SYNC + H_BACK + H_DISP + H_FRONT) begin : g_h_chk
    $error("H_TOTAL does not match the sum of the horizontal intervals");
  end
  if (V_TOTAL != V_SYNC + V_BACK + V_DISP + V_FRONT) begin : g_v_chk
    $error("V_TOTAL does not match the sum of the vertical intervals");
  end

  state_t            state, state_nxt;
  logic              fb;
  logic              sel_ok;
  logic              req_ok;
  logic [BUF_W-1:0]  pending;
  logic [BUF_W-1:0]  eff_sel;
  logic              load_buf;
  logic [FL_W-1:0]   flush_cnt;
  logic [ADDR_W:0]   b_nxt;
  logic [ADDR_W:0]   e_nxt;
  logic              v_win;
  logic              unused_msb;

  // Scan counters
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
    end else begin
      hcnt <= hcnt + CNT_W'(1);
    end
  end

  // A request landing in the boundary cycle bypasses the pending register.
  always_comb begin
    fb      = (hcnt == H_LAST) && (vcnt == V_LAST);
    sel_ok  = {1'b0, buf_sel} < NUM_BUF_C;
    req_ok  = buf_sel_vld && sel_ok;
    eff_sel = req_ok ? buf_sel : pending;
    b_nxt   = (ADDR_W+1)'(eff_sel) * STRIDE_C;
    e_nxt   = b_nxt + FWORDS_C;
    unused_msb = b_nxt[ADDR_W] ^ e_nxt[ADDR_W];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending <= '0;
      sel_err <= 1'b0;
    end else begin
      if (req_ok) pending <= buf_sel;
      sel_err <= buf_sel_vld && !sel_ok;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_buf  = 1'b0;
    case (state)
      IDLE: begin
        if (fb) begin
          load_buf  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (fb && (eff_sel != active_buf)) begin
          load_buf  = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt == FL_LAST) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter sits at zero outside FLUSH, so each flush starts from zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)          flush_cnt <= '0;
    else if (state != FLUSH) flush_cnt <= '0;
    else                     flush_cnt <= flush_cnt + FL_W'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active_buf <= '0;
      rd_b_addr  <= '0;
      rd_e_addr  <= FWORDS_C[ADDR_W-1:0];
    end else if (load_buf) begin
      active_buf <= eff_sel;
      rd_b_addr  <= b_nxt[ADDR_W-1:0];
      rd_e_addr  <= e_nxt[ADDR_W-1:0];
    end
  end

  always_comb begin
    v_win       = (vcnt >= V_DE_B) && (vcnt < V_DE_E);
    hsync       = (hcnt < H_SYN) ? POL : ~POL;
    vsync       = (vcnt < V_SYN) ? POL : ~POL;
    de          = v_win && (hcnt >= H_DE_B) && (hcnt < H_DE_E);
    rd_en       = v_win && (hcnt >= H_RD_B) && (hcnt < H_RD_E) && (state == RUN);
    sdram_rst_n = (state == RUN);
    frame_start = (hcnt == '0) && (vcnt == '0);
  end

endmodule

// File: tb/tb_vga_frame_rd_sync.sv
// Bench for vga_frame_rd_sync: two instances (4 and 3 buffers) on a small
// timing, checked every cycle against a frame-position reference model.
module tb_vga_frame_rd_sync;

  localparam int HT    = 14;
  localparam int VT    = 8;
  localparam int FRAME = HT * VT;
  localparam int RSTL  = 4;
  localparam longint unsigned STRIDE = 1048576;
  localparam longint unsigned FWORDS = 786432;

  typedef struct {
    int unsigned t;
    bit          started;
    int unsigned act;
    int unsigned pend;
    int unsigned flush_end;
    bit          err;
  } mstate_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic [1:0] buf_sel;
  logic buf_sel_vld;

  logic [1:0][11:0] hcnt_o, vcnt_o;
  logic [1:0][22:0] rdb_o, rde_o;
  logic [1:0][1:0]  act_o;
  logic [1:0] hsync_o, vsync_o, de_o, rd_en_o, srst_o, fs_o, err_o;

  mstate_t m [2];
  int n_chk = 0;
  int n_pass = 0;
  int fs_c, de_c, rd_c, lo_c, lo3_c, err3_c;

  always #5 sys_clk = ~sys_clk;

  vga_frame_rd_sync #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(1), .H_TOTAL(HT),
    .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1), .V_TOTAL(VT),
    .CNT_W(12), .SYNC_POL(1), .RD_LEAD(1), .NUM_BUF(4), .BUF_W(2),
    .ADDR_W(23), .BUF_STRIDE(1048576), .FRAME_WORDS(786432), .RST_LEN(RSTL)
  ) dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .buf_sel(buf_sel), .buf_sel_vld(buf_sel_vld),
    .hcnt(hcnt_o[0]), .vcnt(vcnt_o[0]), .hsync(hsync_o[0]), .vsync(vsync_o[0]),
    .de(de_o[0]), .rd_en(rd_en_o[0]), .sdram_rst_n(srst_o[0]),
    .rd_b_addr(rdb_o[0]), .rd_e_addr(rde_o[0]), .active_buf(act_o[0]),
    .frame_start(fs_o[0]), .sel_err(err_o[0])
  );

  vga_frame_rd_sync #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(1), .H_TOTAL(HT),
    .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1), .V_TOTAL(VT),
    .CNT_W(12), .SYNC_POL(1), .RD_LEAD(1), .NUM_BUF(3), .BUF_W(2),
    .ADDR_W(23), .BUF_STRIDE(1048576), .FRAME_WORDS(786432), .RST_LEN(RSTL)
  ) dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .buf_sel(buf_sel), .buf_sel_vld(buf_sel_vld),
    .hcnt(hcnt_o[1]), .vcnt(vcnt_o[1]), .hsync(hsync_o[1]), .vsync(vsync_o[1]),
    .de(de_o[1]), .rd_en(rd_en_o[1]), .sdram_rst_n(srst_o[1]),
    .rd_b_addr(rdb_o[1]), .rd_e_addr(rde_o[1]), .active_buf(act_o[1]),
    .frame_start(fs_o[1]), .sel_err(err_o[1])
  );

  function automatic mstate_t reset_model();
    mstate_t s;
    s.t = 0; s.started = 1'b0; s.act = 0; s.pend = 0; s.flush_end = 0; s.err = 1'b0;
    return s;
  endfunction

  // One clock of the reference: requests, then what happens at a frame's last cycle.
  function automatic mstate_t next_model(mstate_t s, bit vld, int unsigned sel, int unsigned nbuf);
    mstate_t n;
    int unsigned eff;
    n = s;
    n.err = 1'b0;
    eff = s.pend;
    if (vld) begin
      if (sel < nbuf) begin
        n.pend = sel;
        eff = sel;
      end else begin
        n.err = 1'b1;
      end
    end
    if (s.t % FRAME == FRAME - 1) begin
      if (!s.started) begin
        n.started = 1'b1;
        n.act = eff;
      end else if (eff != s.act) begin
        n.act = eff;
        n.flush_end = s.t + 1 + RSTL;
      end
    end
    n.t = s.t + 1;
    return n;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m[0] <= reset_model();
      m[1] <= reset_model();
    end else begin
      m[0] <= next_model(m[0], buf_sel_vld, buf_sel, 4);
      m[1] <= next_model(m[1], buf_sel_vld, buf_sel, 3);
    end
  end

  task automatic chk(input string nm, input int i, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d, want %0d", nm, i, act, exp);
  endtask

  task automatic cmp_inst(input int i);
    int unsigned fc, h, v;
    bit run, vw;
    fc  = m[i].t % FRAME;
    h   = fc % HT;
    v   = fc / HT;
    run = m[i].started && (m[i].t >= m[i].flush_end);
    vw  = (v >= 3) && (v < 7);
    chk("hcnt", i, 64'(hcnt_o[i]), h);
    chk("vcnt", i, 64'(vcnt_o[i]), v);
    chk("hsync", i, 64'(hsync_o[i]), (h < 2) ? 1 : 0);
    chk("vsync", i, 64'(vsync_o[i]), (v < 1) ? 1 : 0);
    chk("de", i, 64'(de_o[i]), (vw && h >= 5 && h < 13) ? 1 : 0);
    chk("rd_en", i, 64'(rd_en_o[i]), (run && vw && h >= 4 && h < 12) ? 1 : 0);
    chk("sdram_rst_n", i, 64'(srst_o[i]), run ? 1 : 0);
    chk("frame_start", i, 64'(fs_o[i]), (fc == 0) ? 1 : 0);
    chk("active_buf", i, 64'(act_o[i]), m[i].act);
    chk("rd_b_addr", i, 64'(rdb_o[i]), m[i].act * STRIDE);
    chk("rd_e_addr", i, 64'(rde_o[i]), m[i].act * STRIDE + FWORDS);
    chk("sel_err", i, 64'(err_o[i]), m[i].err ? 1 : 0);
  endtask

  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) cmp_inst(i);
  end

  task automatic cyc(input bit vld, input int unsigned sel);
    fs_c   += int'(fs_o[0]);
    de_c   += int'(de_o[0]);
    rd_c   += int'(rd_en_o[0]);
    lo_c   += int'(!srst_o[0]);
    lo3_c  += int'(!srst_o[1]);
    err3_c += int'(err_o[1]);
    buf_sel_vld = vld;
    buf_sel = sel[1:0];
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clr();
    fs_c = 0; de_c = 0; rd_c = 0; lo_c = 0; lo3_c = 0; err3_c = 0;
  endtask

  task automatic run_frame(input int pa, input int unsigned sa, input int pb, input int unsigned sb);
    clr();
    for (int c = 0; c < FRAME; c++) begin
      if (c == pa)      cyc(1'b1, sa);
      else if (c == pb) cyc(1'b1, sb);
      else              cyc(1'b0, $urandom_range(0, 3));
    end
  endtask

  initial begin
    int unsigned nsel;
    sys_rst_n = 1'b0;
    buf_sel_vld = 1'b0;
    buf_sel = '0;
    repeat (3) @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // Two plain frames: idle first, reading in the second.
    run_frame(-1, 0, -1, 0);
    chk("f1_frame_starts", 0, fs_c, 1);
    chk("f1_de_cycles", 0, de_c, 32);
    chk("f1_rd_cycles", 0, rd_c, 0);
    chk("f1_rst_low", 0, lo_c, FRAME);
    run_frame(-1, 0, -1, 0);
    chk("f2_frame_starts", 0, fs_c, 1);
    chk("f2_de_cycles", 0, de_c, 32);
    chk("f2_rd_cycles", 0, rd_c, 32);
    chk("f2_rst_low", 0, lo_c, 0);

    // Switch to buffer 2 mid-frame; sampled now at the next frame_start.
    run_frame(50, 2, -1, 0);
    chk("sw2_active", 0, 64'(act_o[0]), 2);
    chk("sw2_b_addr", 0, 64'(rdb_o[0]), 2097152);
    chk("sw2_e_addr", 0, 64'(rde_o[0]), 2883584);
    chk("sw2_rst_low_now", 0, 64'(srst_o[0]), 0);

    // Two requests in one frame: 1 then 3 (3 is out of range for dut3).
    run_frame(20, 1, 60, 3);
    chk("sw2_flush_len", 0, lo_c, RSTL);
    chk("sw13_err3", 1, err3_c, 1);
    chk("sw13_active", 0, 64'(act_o[0]), 3);
    chk("sw13_active3", 1, 64'(act_o[1]), 1);

    // Request equal to the active buffer (and invalid for dut3).
    run_frame(40, 3, -1, 0);
    chk("sw13_flush_len", 0, lo_c, RSTL);
    chk("same_err3", 1, err3_c, 1);
    chk("same_no_flush", 0, 64'(srst_o[0]), 1);
    chk("same_active3", 1, 64'(act_o[1]), 1);

    // Request exactly in the boundary cycle.
    run_frame(FRAME - 1, 0, -1, 0);
    chk("same_rst_low", 0, lo_c, 0);
    chk("same_rst_low3", 1, lo3_c, 0);
    chk("fb_active", 0, 64'(act_o[0]), 0);
    chk("fb_active3", 1, 64'(act_o[1]), 0);
    run_frame(-1, 0, -1, 0);
    chk("fb_flush_len", 0, lo_c, RSTL);
    chk("fb_flush_len3", 1, lo3_c, RSTL);

    // Random request traffic, including boundary-cycle hits.
    for (int f = 0; f < 8; f++) begin
      clr();
      for (int c = 0; c < FRAME; c++)
        cyc(($urandom_range(0, 15) == 0) || (c == FRAME - 1 && $urandom_range(0, 1) == 1),
            $urandom_range(0, 3));
    end

    // Reset in the middle of a flush.
    nsel = (m[0].act == 1) ? 2 : 1;
    run_frame(30, nsel, -1, 0);
    cyc(1'b0, 0);
    cyc(1'b0, 0);
    chk("mid_flush_rst_n", 0, 64'(srst_o[0]), 0);
    chk("mid_flush_active", 0, 64'(act_o[0]), nsel);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_hcnt", 0, 64'(hcnt_o[0]), 0);
    chk("rst_active", 0, 64'(act_o[0]), 0);
    chk("rst_b_addr", 0, 64'(rdb_o[0]), 0);
    chk("rst_e_addr", 0, 64'(rde_o[0]), FWORDS);
    chk("rst_sdram_rst_n", 0, 64'(srst_o[0]), 0);
    chk("rst_frame_start", 0, 64'(fs_o[0]), 1);
    chk("rst_hsync", 0, 64'(hsync_o[0]), 1);
    @(negedge sys_clk);
    #1;
    @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    run_frame(-1, 0, -1, 0);
    chk("post_rst_low", 0, lo_c, FRAME);
    chk("post_rst_rd", 0, rd_c, 0);
    chk("post_rst_active", 0, 64'(act_o[0]), 0);
    run_frame(-1, 0, -1, 0);
    chk("post_rst2_low", 0, lo_c, 0);
    chk("post_rst2_rd", 0, rd_c, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
